// File: rtl/i2s_sample_rx.sv
// I2S receiver: deserializes codec left/right words into DATA_SIZE-bit stereo pairs
// and presents each complete frame with a one-cycle out_ready strobe in the clk domain.
module i2s_sample_rx #(
  parameter int unsigned DATA_SIZE = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lrck,
  input  logic                 i2s_sdata,
  output logic [DATA_SIZE-1:0] out_left,
  output logic [DATA_SIZE-1:0] out_right,
  output logic                 out_ready,
  output logic                 word_short
);

  localparam int unsigned CntW = $clog2(DATA_SIZE + 1);
  localparam logic [DATA_SIZE-1:0] MsbMask = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_SIZE);

  typedef enum logic [0:0] {StUnlocked, StLocked} lock_e;

  // Two synchronizer flops plus one extra stage per input; bclk keeps one more for edge detect.
  logic [2:0] bclk_sync_q;
  logic [2:0] lrck_sync_q;
  logic [2:0] sdata_sync_q;
  logic       bclk_prev_q;

  lock_e                 state_q;
  logic                  lrck_last_q;
  logic [DATA_SIZE-1:0]  word_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [DATA_SIZE-1:0]  hold_l_q;
  logic [DATA_SIZE-1:0]  hold_r_q;
  logic                  short_l_q;
  logic                  short_r_q;
  logic                  have_left_q;
  logic [DATA_SIZE-1:0]  out_left_q;
  logic [DATA_SIZE-1:0]  out_right_q;
  logic                  out_ready_q;
  logic                  word_short_q;

  logic                  bclk_s;
  logic                  lrck_s;
  logic                  sdata_s;
  logic                  bclk_rise;
  logic                  lrck_changed;
  logic                  left_close;
  logic                  right_close;
  logic [DATA_SIZE-1:0]  bit_mask;
  logic [DATA_SIZE-1:0]  word_store;
  logic [CntW-1:0]       cnt_store;
  logic                  short_now;

  assign bclk_s    = bclk_sync_q[2];
  assign lrck_s    = lrck_sync_q[2];
  assign sdata_s   = sdata_sync_q[2];
  assign bclk_rise = bclk_s & ~bclk_prev_q;

  assign lrck_changed = lrck_s != lrck_last_q;
  assign left_close   = lrck_changed & lrck_s;
  assign right_close  = lrck_changed & ~lrck_s;

  // Word after storing the current bit; the closing bit of a word is stored the same way.
  always_comb begin
    bit_mask   = MsbMask >> bit_cnt_q;
    word_store = word_q;
    cnt_store  = bit_cnt_q;
    if (bit_cnt_q < CntFull) begin
      word_store = word_q | (sdata_s ? bit_mask : '0);
      cnt_store  = bit_cnt_q + CntW'(1);
    end
    short_now = cnt_store < CntFull;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      sdata_sync_q <= '0;
      bclk_prev_q  <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[1:0], i2s_bclk};
      lrck_sync_q  <= {lrck_sync_q[1:0], i2s_lrck};
      sdata_sync_q <= {sdata_sync_q[1:0], i2s_sdata};
      bclk_prev_q  <= bclk_sync_q[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StUnlocked;
      lrck_last_q  <= 1'b0;
      word_q       <= '0;
      bit_cnt_q    <= '0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      short_l_q    <= 1'b0;
      short_r_q    <= 1'b0;
      have_left_q  <= 1'b0;
      out_left_q   <= '0;
      out_right_q  <= '0;
      out_ready_q  <= 1'b0;
      word_short_q <= 1'b0;
    end else begin
      out_ready_q  <= 1'b0;
      word_short_q <= 1'b0;
      if (bclk_rise) begin
        lrck_last_q <= lrck_s;
        if (lrck_changed) begin
          word_q    <= '0;
          bit_cnt_q <= '0;
        end else begin
          word_q    <= word_store;
          bit_cnt_q <= cnt_store;
        end
        if (left_close) begin
          hold_l_q    <= word_store;
          short_l_q   <= short_now;
          have_left_q <= 1'b1;
        end
        if (right_close) begin
          hold_r_q    <= word_store;
          short_r_q   <= short_now;
          have_left_q <= 1'b0;
          unique case (state_q)
            StUnlocked: state_q <= StLocked;
            StLocked: begin
              // A right close without a preceding left close is dropped silently.
              if (have_left_q) begin
                out_left_q   <= hold_l_q;
                out_right_q  <= word_store;
                out_ready_q  <= 1'b1;
                word_short_q <= short_l_q | short_now;
              end
            end
            default: state_q <= StUnlocked;
          endcase
        end
      end
    end
  end

  assign out_left   = out_left_q;
  assign out_right  = out_right_q;
  assign out_ready  = out_ready_q;
  assign word_short = word_short_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Bench for i2s_sample_rx: builds I2S bit streams from frame lists and scores each strobe
// against the expected left/right/short values and the expected strobe cycle.
module tb_i2s_sample_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrck = 1'b0;
  logic        i2s_sdata = 1'b0;
  logic [23:0] out_left;
  logic [23:0] out_right;
  logic        out_ready;
  logic        word_short;

  i2s_sample_rx #(.DATA_SIZE(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdata (i2s_sdata),
    .out_left  (out_left),
    .out_right (out_right),
    .out_ready (out_ready),
    .word_short(word_short)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [23:0] l;
    logic [23:0] r;
    logic        s;
  } strobe_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        s;
  } pair_t;

  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  strobe_t strobe_q[$];
  pair_t   exp_q[$];
  int      trans_q[$];
  bit      ws_q[$];
  bit      bit_q[$];
  bit      prev_ws = 1'b0;
  bit      last_bit = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_ready) begin
      strobe_t st;
      st.cyc = cyc;
      st.l   = out_left;
      st.r   = out_right;
      st.s   = word_short;
      strobe_q.push_back(st);
    end
  end

  // Left-justify an n-bit MSB-first word into 24 bits.
  function automatic logic [23:0] word_val(input logic [31:0] v, input int n);
    logic [63:0] t;
    t = {32'b0, v};
    if (n >= 24) t = t >> (n - 24);
    else t = t << (24 - n);
    return t[23:0];
  endfunction

  function automatic logic [31:0] rnd_word(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return $urandom & m[31:0];
  endfunction

  task automatic add_word(input bit ws, input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      ws_q.push_back(ws);
      bit_q.push_back(v[k]);
    end
  endtask

  task automatic add_frame(input logic [31:0] lv, input int ln, input logic [31:0] rv,
                           input int rn, input bit emit);
    pair_t p;
    add_word(1'b0, lv, ln);
    add_word(1'b1, rv, rn);
    if (emit) begin
      p.l = word_val(lv, ln);
      p.r = word_val(rv, rn);
      p.s = (ln < 24) || (rn < 24);
      exp_q.push_back(p);
    end
  endtask

  // Each slot: ws and the previous slot's data bit change while bclk is low (I2S delay).
  task automatic drive(input int half);
    while (ws_q.size() > 0) begin
      bit w;
      bit d;
      w = ws_q.pop_front();
      d = bit_q.pop_front();
      @(posedge clk); #1;
      i2s_lrck  = w;
      i2s_sdata = last_bit;
      last_bit  = d;
      repeat (half) @(posedge clk);
      #1 i2s_bclk = 1'b1;
      if (!w && prev_ws) trans_q.push_back(cyc);
      prev_ws = w;
      repeat (half) @(posedge clk);
      #1 i2s_bclk = 1'b0;
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b0;
    i2s_sdata = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    strobe_q.delete();
    exp_q.delete();
    trans_q.delete();
    ws_q.delete();
    bit_q.delete();
    prev_ws = 1'b0;
    last_bit = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      i2s_bclk  = ~i2s_bclk;
      i2s_lrck  = 1'($urandom);
      i2s_sdata = 1'($urandom);
    end
    @(negedge clk);
    total++;
    if (out_left !== 24'h0 || out_right !== 24'h0 || out_ready !== 1'b0 || word_short !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got l=%h r=%h rdy=%b short=%b want all 0",
               out_left, out_right, out_ready, word_short);
    end
    strobe_q.delete();
    @(posedge clk); #1;
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b0;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (strobe_q.size() != 0 || out_left !== 24'h0 || out_right !== 24'h0) begin
      bad++;
      $display("FAIL reset_idle: got strobes=%0d l=%h r=%h want 0 strobes and zero outputs",
               strobe_q.size(), out_left, out_right);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    for (int f = 0; f < 4; f++)
      add_frame({24'hA55AF0, 8'($urandom)}, 32, {24'h0F1E2D, 8'($urandom)}, 32, f > 0);
    add_word(1'b0, 32'h0, 2);
    drive(8);
    total++;
    if (strobe_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL nominal_count: got %0d want %0d", strobe_q.size(), exp_q.size());
    end
    for (int i = 0; i < strobe_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({strobe_q[i].l, strobe_q[i].r, strobe_q[i].s} !== {exp_q[i].l, exp_q[i].r, exp_q[i].s}) begin
        bad++;
        $display("FAIL nominal_data[%0d]: got %h/%h/%b want %h/%h/%b", i, strobe_q[i].l,
                 strobe_q[i].r, strobe_q[i].s, exp_q[i].l, exp_q[i].r, exp_q[i].s);
      end
      total++;
      if (i + 1 >= trans_q.size() || strobe_q[i].cyc != trans_q[i+1] + 4) begin
        bad++;
        $display("FAIL nominal_latency[%0d]: got cycle %0d want 4 after bclk edge", i,
                 strobe_q[i].cyc);
      end
    end
  endtask

  task automatic test_short_words();
    do_reset();
    for (int f = 0; f < 4; f++) add_frame(32'hBEEF, 16, 32'h1234, 16, f > 0);
    add_word(1'b0, 32'h0, 2);
    drive(4);
    total++;
    if (strobe_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL short_count: got %0d want %0d", strobe_q.size(), exp_q.size());
    end
    for (int i = 0; i < strobe_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({strobe_q[i].l, strobe_q[i].r, strobe_q[i].s} !== {24'hBEEF00, 24'h123400, 1'b1}) begin
        bad++;
        $display("FAIL short_data[%0d]: got %h/%h/%b want beef00/123400/1", i,
                 strobe_q[i].l, strobe_q[i].r, strobe_q[i].s);
      end
    end
  endtask

  task automatic test_mid_frame_start();
    do_reset();
    add_word(1'b1, rnd_word(10), 10);
    for (int f = 0; f < 2; f++) add_frame(rnd_word(24), 24, rnd_word(24), 24, 1'b1);
    add_word(1'b0, 32'h0, 2);
    drive(4);
    total++;
    if (strobe_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL midstart_count: got %0d want %0d", strobe_q.size(), exp_q.size());
    end
    for (int i = 0; i < strobe_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({strobe_q[i].l, strobe_q[i].r, strobe_q[i].s} !== {exp_q[i].l, exp_q[i].r, exp_q[i].s}) begin
        bad++;
        $display("FAIL midstart_data[%0d]: got %h/%h/%b want %h/%h/%b", i, strobe_q[i].l,
                 strobe_q[i].r, strobe_q[i].s, exp_q[i].l, exp_q[i].r, exp_q[i].s);
      end
      total++;
      if (i + 1 >= trans_q.size() || strobe_q[i].cyc != trans_q[i+1] + 4) begin
        bad++;
        $display("FAIL midstart_timing[%0d]: got cycle %0d", i, strobe_q[i].cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nf;
    nf = 160;
    do_reset();
    for (int f = 0; f < nf; f++) begin
      int ln;
      int rn;
      ln = $urandom_range(20, 28);
      rn = $urandom_range(20, 28);
      add_frame(rnd_word(ln), ln, rnd_word(rn), rn, f > 0);
    end
    add_word(1'b0, 32'h0, 2);
    drive(3);
    total++;
    if (strobe_q.size() != nf - 1) begin
      bad++;
      $display("FAIL stream_count: got %0d want %0d", strobe_q.size(), nf - 1);
    end
    for (int i = 0; i < strobe_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({strobe_q[i].l, strobe_q[i].r, strobe_q[i].s} !== {exp_q[i].l, exp_q[i].r, exp_q[i].s}) begin
        bad++;
        $display("FAIL stream_data[%0d]: got %h/%h/%b want %h/%h/%b", i, strobe_q[i].l,
                 strobe_q[i].r, strobe_q[i].s, exp_q[i].l, exp_q[i].r, exp_q[i].s);
      end
      total++;
      if (i + 1 >= trans_q.size() || strobe_q[i].cyc != trans_q[i+1] + 4) begin
        bad++;
        $display("FAIL stream_spacing[%0d]: got cycle %0d", i, strobe_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] lv3;
    do_reset();
    for (int f = 0; f < 3; f++) add_frame(rnd_word(24), 24, rnd_word(24), 24, f > 0);
    lv3 = rnd_word(24);
    add_word(1'b0, lv3 >> 14, 10);
    drive(4);
    total++;
    if (strobe_q.size() != 2 || exp_q.size() != 2 || strobe_q[1].l !== exp_q[1].l ||
        strobe_q[1].r !== exp_q[1].r) begin
      bad++;
      $display("FAIL rstmid_pre: got %0d strobes want 2 with matching last pair", strobe_q.size());
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_left !== 24'h0 || out_right !== 24'h0 || out_ready !== 1'b0 || word_short !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_clear: got l=%h r=%h rdy=%b short=%b want all 0",
               out_left, out_right, out_ready, word_short);
    end
    @(posedge clk); #1 rst = 1'b0;
    strobe_q.delete();
    exp_q.delete();
    trans_q.delete();
    add_word(1'b0, lv3 & 32'h3FFF, 14);
    add_word(1'b1, rnd_word(24), 24);
    for (int f = 0; f < 2; f++) add_frame(rnd_word(24), 24, rnd_word(24), 24, 1'b1);
    add_word(1'b0, 32'h0, 2);
    drive(4);
    total++;
    if (strobe_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rstmid_count: got %0d want %0d", strobe_q.size(), exp_q.size());
    end
    for (int i = 0; i < strobe_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({strobe_q[i].l, strobe_q[i].r, strobe_q[i].s} !== {exp_q[i].l, exp_q[i].r, exp_q[i].s}) begin
        bad++;
        $display("FAIL rstmid_data[%0d]: got %h/%h/%b want %h/%h/%b", i, strobe_q[i].l,
                 strobe_q[i].r, strobe_q[i].s, exp_q[i].l, exp_q[i].r, exp_q[i].s);
      end
      total++;
      if (i + 1 >= trans_q.size() || strobe_q[i].cyc != trans_q[i+1] + 4) begin
        bad++;
        $display("FAIL rstmid_timing[%0d]: got cycle %0d", i, strobe_q[i].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_words();
    test_mid_frame_start();
    test_back_to_back();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
